// File: rtl/mem_ctrl.sv
// Single-port word-addressed RAM front end for the MAR/MDR datapath.
// Accepts one read or write at a time and inserts WAIT_CYCLES wait states before the access.
module mem_ctrl #(
    parameter int unsigned ADDR_BITS   = 9,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Read,
    input  logic        Write,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] MdataIn,
    output logic        MDRead,
    output logic        Busy,
    output logic        Done,
    output logic        Fault
);

    localparam int unsigned Depth = 1 << ADDR_BITS;
    localparam logic [3:0] WaitInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StAccess, StDone} state_t;

    state_t                 state;
    logic [3:0]             wait_cnt;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [31:0]            data_q;
    logic                   op_read;
    logic [31:0]            ram [Depth];

    logic in_range;
    logic req_good;
    logic req_bad;

    always_comb begin
        in_range = (Address[31:ADDR_BITS] == '0);
        req_good = (Read ^ Write) && in_range;
        req_bad  = (Read && Write) || ((Read || Write) && !in_range);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= StIdle;
            wait_cnt <= 4'd0;
            MdataIn  <= 32'd0;
            MDRead   <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Fault    <= 1'b0;
        end else begin
            MDRead <= 1'b0;
            Done   <= 1'b0;
            Fault  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (req_good) begin
                        addr_q  <= Address[ADDR_BITS-1:0];
                        data_q  <= DataIn;
                        op_read <= Read;
                        Busy    <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state <= StAccess;
                        end else begin
                            state    <= StWait;
                            wait_cnt <= WaitInit;
                        end
                    end else if (req_bad) begin
                        // Rejected request: skip the array and report straight away.
                        state <= StDone;
                        Busy  <= 1'b1;
                        Done  <= 1'b1;
                        Fault <= 1'b1;
                    end
                end
                StWait: begin
                    if (wait_cnt == 4'd0) begin
                        state <= StAccess;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                StAccess: begin
                    if (op_read) begin
                        MdataIn <= ram[addr_q];
                        MDRead  <= 1'b1;
                    end
                    Done  <= 1'b1;
                    state <= StDone;
                end
                StDone: begin
                    Busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Reset wins over a write landing on the same edge.
    always_ff @(posedge clk) begin
        if (!reset && state == StAccess && !op_read) begin
            ram[addr_q] <= data_q;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: two instances (2 and 0 wait states) checked every cycle against a
// transaction-level model, plus directed scenarios with literal expectations.
module tb_mem_ctrl;

    localparam int WAITS [2] = '{2, 0};

    logic        clk = 1'b0;
    logic        rst    [2];
    logic        rd     [2];
    logic        wr     [2];
    logic [31:0] addr   [2];
    logic [31:0] din    [2];
    logic [31:0] md_o   [2];
    logic        mdr_o  [2];
    logic        busy_o [2];
    logic        done_o [2];
    logic        flt_o  [2];

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_BITS(9), .WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .reset(rst[0]), .Read(rd[0]), .Write(wr[0]), .Address(addr[0]),
        .DataIn(din[0]), .MdataIn(md_o[0]), .MDRead(mdr_o[0]), .Busy(busy_o[0]),
        .Done(done_o[0]), .Fault(flt_o[0])
    );

    mem_ctrl #(.ADDR_BITS(9), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .reset(rst[1]), .Read(rd[1]), .Write(wr[1]), .Address(addr[1]),
        .DataIn(din[1]), .MdataIn(md_o[1]), .MDRead(mdr_o[1]), .Busy(busy_o[1]),
        .Done(done_o[1]), .Fault(flt_o[1])
    );

    // Model: a request occupies the unit for a fixed number of cycles, the last being the
    // completion cycle; the array effect lands on the edge that enters that cycle.
    int          cnt      [2] = '{0, 0};
    bit          m_flt    [2];
    bit          m_rd     [2];
    int          m_a      [2];
    logic [31:0] m_d      [2];
    logic [31:0] mem_m    [2][512];
    bit          known    [2][512];
    logic [31:0] md_m     [2];
    bit          md_known [2] = '{0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                cnt[i]      = 0;
                md_m[i]     = 32'd0;
                md_known[i] = 1;
            end else if (cnt[i] > 0) begin
                cnt[i] = cnt[i] - 1;
                if (cnt[i] == 1 && !m_flt[i]) begin
                    if (m_rd[i]) begin
                        md_m[i]     = mem_m[i][m_a[i]];
                        md_known[i] = known[i][m_a[i]];
                    end else begin
                        mem_m[i][m_a[i]] = m_d[i];
                        known[i][m_a[i]] = 1;
                    end
                end
            end else if (rd[i] || wr[i]) begin
                if (rd[i] && wr[i] || addr[i] >= 32'd512) begin
                    cnt[i]   = 1;
                    m_flt[i] = 1;
                end else begin
                    cnt[i]   = WAITS[i] + 2;
                    m_flt[i] = 0;
                    m_rd[i]  = rd[i];
                    m_a[i]   = int'(addr[i]);
                    m_d[i]   = din[i];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("busy[%0d]", i), 32'(busy_o[i]), 32'(cnt[i] > 0));
                chk($sformatf("done[%0d]", i), 32'(done_o[i]), 32'(cnt[i] == 1));
                chk($sformatf("mdread[%0d]", i), 32'(mdr_o[i]),
                    32'(cnt[i] == 1 && !m_flt[i] && m_rd[i]));
                chk($sformatf("fault[%0d]", i), 32'(flt_o[i]), 32'(cnt[i] == 1 && m_flt[i]));
                if (md_known[i]) chk($sformatf("mdata[%0d]", i), md_o[i], md_m[i]);
            end
        end
    end

    // Issue one request and return in the completion cycle; edges counts edges after acceptance.
    task automatic run_op(input int i, input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] d, output int edges);
        @(negedge clk);
        rd[i] = r; wr[i] = w; addr[i] = a; din[i] = d;
        @(posedge clk);
        @(negedge clk);
        rd[i] = 0; wr[i] = 0;
        edges = 0;
        while (!done_o[i] && edges < 30) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        if (edges >= 30) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout[%0d]: no Done within 30 edges", i);
        end
    endtask

    task automatic directed(input int i);
        int e;
        int lat;
        lat = WAITS[i] + 1;
        run_op(i, 0, 1, 32'h5, 32'hDEADBEEF, e);
        chk("wr_latency", 32'(e), 32'(lat));
        chk("wr_mdread", 32'(mdr_o[i]), 32'd0);
        chk("wr_mdata_held", md_o[i], 32'd0);
        run_op(i, 1, 0, 32'h5, 32'h0, e);
        chk("rd_latency", 32'(e), 32'(lat));
        chk("rd_mdread", 32'(mdr_o[i]), 32'd1);
        chk("rd_data", md_o[i], 32'hDEADBEEF);
        @(negedge clk);
        chk("rd_done_once", 32'(done_o[i]), 32'd0);
        chk("rd_data_held", md_o[i], 32'hDEADBEEF);
        run_op(i, 1, 0, 32'h200, 32'h0, e);
        chk("oor_latency", 32'(e), 32'd0);
        chk("oor_fault", 32'(flt_o[i]), 32'd1);
        chk("oor_mdread", 32'(mdr_o[i]), 32'd0);
        chk("oor_mdata_held", md_o[i], 32'hDEADBEEF);
        run_op(i, 1, 0, 32'h5, 32'h0, e);
        chk("oor_then_rd", md_o[i], 32'hDEADBEEF);
        run_op(i, 0, 1, 32'h1, 32'h11111111, e);
        run_op(i, 1, 1, 32'h1, 32'h0, e);
        chk("rw_fault", 32'(flt_o[i]), 32'd1);
        chk("rw_latency", 32'(e), 32'd0);
        run_op(i, 1, 0, 32'h1, 32'h0, e);
        chk("rw_ram_kept", md_o[i], 32'h11111111);
        run_op(i, 0, 1, 32'h7, 32'hCAFEF00D, e);
        // Reset one cycle after acceptance: inside WAIT, or on the ACCESS edge with no waits.
        @(negedge clk);
        wr[i] = 1; addr[i] = 32'h7; din[i] = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        wr[i] = 0; rst[i] = 1;
        @(posedge clk);
        @(negedge clk);
        rst[i] = 0;
        chk("rst_busy", 32'(busy_o[i]), 32'd0);
        chk("rst_done", 32'(done_o[i]), 32'd0);
        chk("rst_mdata", md_o[i], 32'd0);
        run_op(i, 1, 0, 32'h7, 32'h0, e);
        chk("rst_write_dropped", md_o[i], 32'hCAFEF00D);
    endtask

    task automatic random_run(input int i, input int cycles);
        int a;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            rst[i] = ($urandom_range(0, 149) == 0);
            a = $urandom_range(0, 15);
            addr[i] = ($urandom_range(0, 15) == 0) ? (32'h200 | $urandom) : 32'(a);
            din[i]  = $urandom;
            rd[i]   = $urandom_range(0, 2) == 0;
            wr[i]   = $urandom_range(0, 2) == 0;
            if (rd[i] && !wr[i] && addr[i] < 32'd512 && !known[i][addr[i][8:0]]) begin
                rd[i] = 0;
                wr[i] = 1;
            end
        end
        @(negedge clk);
        rst[i] = 0; rd[i] = 0; wr[i] = 0;
        repeat (WAITS[i] + 4) @(negedge clk);
    endtask

    initial begin
        rst  = '{1, 1};
        rd   = '{0, 0};
        wr   = '{0, 0};
        addr = '{0, 0};
        din  = '{0, 0};
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = '{0, 0};
        chk_en = 1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_busy", 32'(busy_o[i]), 32'd0);
            chk("reset_done", 32'(done_o[i]), 32'd0);
            chk("reset_mdread", 32'(mdr_o[i]), 32'd0);
            chk("reset_fault", 32'(flt_o[i]), 32'd0);
            chk("reset_mdata", md_o[i], 32'd0);
        end
        directed(0);
        directed(1);
        random_run(0, 1500);
        random_run(1, 1500);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory interface stage directly downstream of the datapath's MAR/MDR pair. Upstream of the MDR's memory-data input.
- Accepts a single-word read or write request, addressed by the MAR output, with write data taken from the MDR output.
- Models a word-addressed synchronous RAM with a configurable number of wait states.
- Returns read data on MdataIn together with an MDRead strobe, so the MDR loads it in the completion cycle.

Parameters:
- ADDR_BITS, 9, number of implemented word-address bits; RAM depth is 2^ADDR_BITS words of 32 bits.
- WAIT_CYCLES, 2, wait-state cycles inserted before the array access; legal range 0..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- Read  in  1  read request; level sampled in IDLE.
- Write  in  1  write request; level sampled in IDLE.
- Address  in  32  word address, driven from the MAR output.
- DataIn  in  32  write data, driven from the MDR output.
- MdataIn  out  32  registered read data, driven to the MDR memory-data input.
- MDRead  out  1  one-cycle strobe selecting MdataIn into the MDR.
- Busy  out  1  high whenever the state is not IDLE.
- Done  out  1  one-cycle completion pulse.
- Fault  out  1  one-cycle pulse, coincident with Done, for a rejected request.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port name reset.
- Reset values: state IDLE; MdataIn=0; MDRead=0; Busy=0; Done=0; Fault=0; wait counter=0. RAM contents are not cleared by reset.
- States: IDLE, WAIT, ACCESS, DONE.
- IDLE, transitions at the rising edge (edge 0):
  - Read xor Write high and Address[31:ADDR_BITS]==0: latch Address[ADDR_BITS-1:0], DataIn and the op.
    - Go to WAIT with counter=WAIT_CYCLES-1.
    - If WAIT_CYCLES==0, go directly to ACCESS.
  - Read and Write both high, or upper address bits nonzero: go to DONE with the fault flag set. No array access.
  - Neither high: stay in IDLE.
- WAIT: decrement the counter each edge. Go to ACCESS on the edge where the counter is 0. The state occupies exactly WAIT_CYCLES cycles.
- ACCESS: lasts one cycle. At its closing edge:
  - Read: MdataIn <= ram[addr].
  - Write: ram[addr] <= latched data; MdataIn unchanged.
  - Then go to DONE.
- DONE: lasts one cycle.
  - Done=1.
  - MDRead=1 only for a successful read.
  - Fault=1 only on the fault path.
  - Returns to IDLE on the next edge.
- Latency: Done is high in the cycle following edge WAIT_CYCLES+1 after the accepting edge 0. The fault path is always 1 edge.
- Sampled inputs: Read, Write, Address and DataIn are ignored outside IDLE, including the DONE cycle. Changes after acceptance do not affect the operation in flight. A request held high through DONE is re-accepted in the next IDLE cycle.
- Back-to-back requests: minimum spacing between acceptances is WAIT_CYCLES+3 cycles.
- MdataIn holds the last read value until the next successful read; it is not modified by writes or faults.
- Reset mid-operation:
  - The next state is IDLE and all outputs go to their reset values.
  - A write whose ACCESS edge coincides with reset is not committed; reset takes priority.
- Address wrap: no wrap-around. Out-of-range addresses fault; they are never aliased.
- Write-then-read of the same address returns the new data.
- Uninitialised RAM reads are X in simulation. The bench must write before reading.

Test Plan:
- Reset for 2 cycles, then idle -> Busy=Done=MDRead=Fault=0, MdataIn=0x00000000.
- Write addr 0x05 data 0xDEADBEEF, WAIT_CYCLES=2 -> Busy for 4 cycles; Done pulses once at edge 3 after acceptance; MDRead=0; MdataIn unchanged.
- Read addr 0x05 -> Done and MDRead both high for exactly one cycle at edge 3; MdataIn=0xDEADBEEF, held afterwards.
- Read addr 0x00000200 (ADDR_BITS=9) -> Done=Fault=1 one edge after acceptance, MDRead=0; a subsequent read of 0x05 still returns 0xDEADBEEF.
- Read=Write=1 at addr 0x01 -> Fault pulse; ram[1] unchanged (verified by prior write 0x11111111 and a later read).
- Reset asserted during WAIT of a write of 0x12345678 to addr 0x07 holding 0xCAFEF00D -> IDLE next cycle, no Done; a later read of 0x07 returns 0xCAFEF00D. Repeat with WAIT_CYCLES=0, where Done occurs at edge 1.
